// File: rtl/inverse_factorial.sv
// ============================================================================
//  Module      : inverse_factorial
//  Description : Multi-cycle inverse factorial. Finds the largest n with
//                n! <= y by iterative multiplication, one step per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inverse_factorial #(
    parameter int WIDTH = 16,
    parameter int NW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    n_out,
    output logic             exact,
    output logic             err
);

    localparam int PW = WIDTH + NW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_y_q;
    logic [WIDTH-1:0]   w_y_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [NW-1:0]      r_k;
    logic [NW-1:0]      w_k_nxt;
    logic [NW-1:0]      w_kp1;
    logic [NW-1:0]      r_n_out;
    logic [NW-1:0]      w_n_nxt;
    logic               r_exact;
    logic               w_exact_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [PW-1:0]      w_nxt;

    // Full-width product: acc <= y_q always, so acc*(k+1) fits in PW bits.
    assign w_kp1 = r_k + 1'b1;
    assign w_nxt = PW'(r_acc) * PW'(w_kp1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_y_q   <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_n_out <= '0;
            r_exact <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_y_q   <= w_y_nxt;
            r_acc   <= w_acc_nxt;
            r_k     <= w_k_nxt;
            r_n_out <= w_n_nxt;
            r_exact <= w_exact_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y_q;
        w_acc_nxt   = r_acc;
        w_k_nxt     = r_k;
        w_n_nxt     = r_n_out;
        w_exact_nxt = r_exact;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_y_nxt     = y_in;
                    w_acc_nxt   = WIDTH'(1);
                    w_k_nxt     = NW'(1);
                    w_exact_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_y_q == '0) begin
                    w_n_nxt     = '0;
                    w_exact_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_nxt <= PW'(r_y_q)) begin
                    w_acc_nxt = w_nxt[WIDTH-1:0];
                    w_k_nxt   = w_kp1;
                end else begin
                    // Next factorial overshoots: k is the answer.
                    w_n_nxt     = r_k;
                    w_exact_nxt = (r_acc == r_y_q);
                    w_err_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy  = (r_state == S_CALC);
    assign done  = r_done;
    assign n_out = r_n_out;
    assign exact = r_exact;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_inverse_factorial.sv
// ============================================================================
//  Module      : tb_inverse_factorial
//  Description : Directed, table-driven self-checking bench for
//                inverse_factorial.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inverse_factorial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] y_in;
    logic        busy;
    logic        done;
    logic [3:0]  n_out;
    logic        exact;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    inverse_factorial #(.WIDTH(16), .NW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .n_out (n_out),
        .exact (exact),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        int          n;
        int          ex;
        int          er;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits for done after an accepting edge; lat counts edges up to done.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] y,
                          input int en, input int eex, input int eer,
                          input int elat);
        int lat;
        @(negedge clk);
        start = 1'b1;
        y_in  = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, " busy_after_accept"}, int'(busy), 1);
        wait_done(lat);
        chk({name, " latency"}, lat, elat);
        chk({name, " n_out"}, int'(n_out), en);
        chk({name, " exact"}, int'(exact), eex);
        chk({name, " err"}, int'(err), eer);
        @(posedge clk);
        #1;
        chk({name, " done_pulse_end"}, int'(done), 0);
        chk({name, " n_out_hold"}, int'(n_out), en);
        chk({name, " busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        int lat;
        int done_seen;

        //          y       n  ex er lat
        vecs[0]  = '{16'd1,     1, 1, 0, 1};
        vecs[1]  = '{16'd24,    4, 1, 0, 4};
        vecs[2]  = '{16'd100,   4, 0, 0, 4};
        vecs[3]  = '{16'd0,     0, 0, 1, 1};
        vecs[4]  = '{16'd40320, 8, 1, 0, 8};
        vecs[5]  = '{16'd65535, 8, 0, 0, 8};
        vecs[6]  = '{16'd2,     2, 1, 0, 2};
        vecs[7]  = '{16'd6,     3, 1, 0, 3};
        vecs[8]  = '{16'd120,   5, 1, 0, 5};
        vecs[9]  = '{16'd720,   6, 1, 0, 6};
        vecs[10] = '{16'd5040,  7, 1, 0, 7};
        vecs[11] = '{16'd5,     2, 0, 0, 2};
        vecs[12] = '{16'd40319, 7, 0, 0, 7};

        rst_n = 1'b0;
        start = 1'b0;
        y_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset n_out", int'(n_out), 0);
        chk("reset exact", int'(exact), 0);
        chk("reset err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d_y%0d", i, vecs[i].y), vecs[i].y,
                   vecs[i].n, vecs[i].ex, vecs[i].er, vecs[i].lat);
        end

        // Accepting edge clears exact/err but keeps the previous n_out.
        run_op("pre_err", 16'd0, 0, 0, 1, 1);
        run_op("pre_n", 16'd24, 4, 1, 0, 4);
        @(negedge clk);
        start = 1'b1;
        y_in  = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept keeps n_out", int'(n_out), 4);
        chk("accept clears exact", int'(exact), 0);
        wait_done(lat);
        chk("accept y0 err", int'(err), 1);

        // Start held high while busy, with y_in changing: ignored.
        @(negedge clk);
        start = 1'b1;
        y_in  = 16'd6;
        @(posedge clk);
        #1;
        y_in = 16'd720;
        done_seen = 0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_start latency", lat, 3);
        chk("hold_start n_out", int'(n_out), 3);
        chk("hold_start exact", int'(exact), 1);
        // Back-to-back: start in the done cycle is accepted.
        @(negedge clk);
        y_in = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b busy", int'(busy), 1);
        chk("b2b done_cleared", int'(done), 0);
        wait_done(lat);
        chk("b2b latency", lat, 2);
        chk("b2b n_out", int'(n_out), 2);
        chk("b2b exact", int'(exact), 1);

        // Async reset mid-calculation.
        @(negedge clk);
        start = 1'b1;
        y_in  = 16'd720;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst busy", int'(busy), 0);
        chk("async_rst done", int'(done), 0);
        chk("async_rst n_out", int'(n_out), 0);
        chk("async_rst exact", int'(exact), 0);
        chk("async_rst err", int'(err), 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
            if (i == 2) rst_n = 1'b1;
        end
        chk("async_rst no_done", done_seen, 0);
        chk("async_rst idle", int'(busy), 0);
        run_op("post_rst_y6", 16'd6, 3, 1, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
